clk_period_meas: RTL and testbench

//  Downstream monitor for the divided clock from the clock divider, in the same clk domain.

---
 rtl/clk_period_meas_pkg.sv | 14 +
 rtl/clk_period_meas_if.sv | 41 ++++
 rtl/clk_period_meas_edge_det.sv | 26 ++
 rtl/clk_period_meas.sv | 152 +++++++++++++++
 tb/tb_clk_period_meas.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_period_meas_pkg.sv
// Shared definitions for the clock period monitor: FSM encoding and default counter width.
// Optional checker feature is selected with macro CLK_MEAS_CHECK_EN.
package clk_period_meas_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEAS_HIGH = 2'd2,
        ST_MEAS_LOW  = 2'd3
    } meas_state_e;

endpackage

// File: rtl/clk_period_meas_if.sv
// Signal bundle between the period monitor and its user.
// With CLK_MEAS_CHECK_EN defined the bundle also carries exp_period and mismatch.
interface clk_period_meas_if
    import clk_period_meas_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             sig_in;
    logic             meas_en;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W:0]   period;
    logic             meas_valid;
    logic             meas_ovf;
`ifdef CLK_MEAS_CHECK_EN
    logic [CNT_W:0]   exp_period;
    logic             mismatch;

    modport master (
        output sig_in, meas_en, exp_period,
        input  high_cnt, low_cnt, period, meas_valid, meas_ovf, mismatch
    );

    modport slave (
        input  sig_in, meas_en, exp_period,
        output high_cnt, low_cnt, period, meas_valid, meas_ovf, mismatch
    );
`else
    modport master (
        output sig_in, meas_en,
        input  high_cnt, low_cnt, period, meas_valid, meas_ovf
    );

    modport slave (
        input  sig_in, meas_en,
        output high_cnt, low_cnt, period, meas_valid, meas_ovf
    );
`endif

endinterface

// File: rtl/clk_period_meas_edge_det.sv
// Single-register rise/fall detector for a signal already synchronous to clk.
// Not affected by CLK_MEAS_CHECK_EN.
module clk_period_meas_edge_det
    import clk_period_meas_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic sig_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_d_q <= 1'b0;
        end else begin
            sig_d_q <= sig_in;
        end
    end

    assign rise = sig_in & ~sig_d_q;
    assign fall = ~sig_in & sig_d_q;

endmodule

// File: rtl/clk_period_meas.sv
// Measures high time, low time and period of a divided clock in clk cycles.
// Macro CLK_MEAS_CHECK_EN adds the exp_period compare and the mismatch flag.
module clk_period_meas
    import clk_period_meas_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    clk_period_meas_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // state        | meaning
    // ST_IDLE      | disabled, counters cleared, results held
    // ST_WAIT_RISE | discarding the partial first period
    // ST_MEAS_HIGH | counting high cycles since the last rise
    // ST_MEAS_LOW  | counting low cycles; next rise publishes
    meas_state_e state_q, state_d;

    logic             rise, fall;
    logic             publish;
    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] lc_q, lc_d;
    logic             sat_q, sat_d;
    logic [CNT_W:0]   period_sum;

    logic [CNT_W-1:0] high_q, low_q;
    logic [CNT_W:0]   period_q;
    logic             valid_q, ovf_q;

    clk_period_meas_edge_det u_edge_det (
        .clk    (clk),
        .rst    (rst),
        .sig_in (bus.sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.meas_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_WAIT_RISE;
                ST_WAIT_RISE: if (rise) state_d = ST_MEAS_HIGH;
                ST_MEAS_HIGH: if (fall) state_d = ST_MEAS_LOW;
                ST_MEAS_LOW:  if (rise) state_d = ST_MEAS_HIGH;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    // The publishing rise is honoured even when meas_en drops in the same cycle.
    always_comb begin
        publish = (state_q == ST_MEAS_LOW) && rise;
        hc_d    = hc_q;
        lc_d    = lc_q;
        sat_d   = sat_q;
        if (!bus.meas_en) begin
            hc_d  = '0;
            lc_d  = '0;
            sat_d = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_RISE, ST_MEAS_LOW: begin
                    if (rise) begin
                        hc_d  = CNT_ONE;
                        lc_d  = '0;
                        sat_d = 1'b0;
                    end else if (state_q == ST_MEAS_LOW && !bus.sig_in) begin
                        if (lc_q == CNT_MAX) sat_d = 1'b1;
                        else                 lc_d  = lc_q + CNT_ONE;
                    end
                end
                ST_MEAS_HIGH: begin
                    if (fall) begin
                        lc_d = CNT_ONE;
                    end else if (bus.sig_in) begin
                        if (hc_q == CNT_MAX) sat_d = 1'b1;
                        else                 hc_d  = hc_q + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q  <= '0;
            lc_q  <= '0;
            sat_q <= 1'b0;
        end else begin
            hc_q  <= hc_d;
            lc_q  <= lc_d;
            sat_q <= sat_d;
        end
    end

    assign period_sum = {1'b0, hc_q} + {1'b0, lc_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_q   <= '0;
            low_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            valid_q <= publish;
            if (publish) begin
                high_q   <= hc_q;
                low_q    <= lc_q;
                period_q <= period_sum;
                ovf_q    <= sat_q;
            end
        end
    end

`ifdef CLK_MEAS_CHECK_EN
    logic mismatch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else if (publish) begin
            mismatch_q <= (period_sum != bus.exp_period) | sat_q;
        end
    end

    assign bus.mismatch = mismatch_q;
`endif

    assign bus.high_cnt   = high_q;
    assign bus.low_cnt    = low_q;
    assign bus.period     = period_q;
    assign bus.meas_valid = valid_q;
    assign bus.meas_ovf   = ovf_q;

endmodule

// File: tb/tb_clk_period_meas.sv
// Bench for clk_period_meas: two widths driven by one stimulus, checked against a timestamp model.
// Covers CLK_MEAS_CHECK_EN when the macro is defined.
module tb_clk_period_meas;
    import clk_period_meas_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clk_period_meas_if #(.CNT_W(8)) bus8 ();
    clk_period_meas_if #(.CNT_W(4)) bus4 ();

    clk_period_meas #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    clk_period_meas #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int checks = 0;
    int failures = 0;

    // model: outputs per width, derived from rise/fall timestamps
    int mx[2] = '{255, 15};
    int m_high[2], m_low[2], m_per[2], m_val[2], m_ovf[2], m_mis[2];
    int t, cnt_from, p, f;
    logic prev_sig;
    logic [8:0] exp_p;

    // observed DUT strobes for hand-computed checks
    int nv8, lt8, iv8, lh8, ll8, lp8, lo8;
    int nv4, lh4, ll4, lp4, lo4;
    logic q_mis[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0d)", nm, act, exp, t);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_high[k] = 0; m_low[k] = 0; m_per[k] = 0;
            m_val[k] = 0;  m_ovf[k] = 0; m_mis[k] = 0;
        end
        prev_sig = 1'b0;
        cnt_from = t + 1;
        p = -1;
        f = -1;
        lt8 = -1;
    endtask

    task automatic model_step(input logic s, input logic e);
        int h, l, ep;
        logic rise, fall;
        rise = s & ~prev_sig;
        fall = ~s & prev_sig;
        for (int k = 0; k < 2; k++) m_val[k] = 0;
        if (rise) begin
            if (p >= 0 && p >= cnt_from) begin
                h = f - p;
                l = t - f;
                for (int k = 0; k < 2; k++) begin
                    ep = (k == 0) ? int'(exp_p) : int'(exp_p[4:0]);
                    m_high[k] = (h > mx[k]) ? mx[k] : h;
                    m_low[k]  = (l > mx[k]) ? mx[k] : l;
                    m_per[k]  = m_high[k] + m_low[k];
                    m_ovf[k]  = (h > mx[k] || l > mx[k]) ? 1 : 0;
                    m_val[k]  = 1;
                    m_mis[k]  = (m_per[k] != ep || m_ovf[k] == 1) ? 1 : 0;
                end
            end
            p = (t >= cnt_from) ? t : -1;
        end
        if (fall) f = t;
        if (!e) cnt_from = t + 2;
        prev_sig = s;
        t++;
    endtask

    task automatic cmp_all();
        chk("valid8",  int'(bus8.meas_valid), m_val[0]);
        chk("high8",   int'(bus8.high_cnt),   m_high[0]);
        chk("low8",    int'(bus8.low_cnt),    m_low[0]);
        chk("period8", int'(bus8.period),     m_per[0]);
        chk("ovf8",    int'(bus8.meas_ovf),   m_ovf[0]);
        chk("valid4",  int'(bus4.meas_valid), m_val[1]);
        chk("high4",   int'(bus4.high_cnt),   m_high[1]);
        chk("low4",    int'(bus4.low_cnt),    m_low[1]);
        chk("period4", int'(bus4.period),     m_per[1]);
        chk("ovf4",    int'(bus4.meas_ovf),   m_ovf[1]);
`ifdef CLK_MEAS_CHECK_EN
        chk("mis8",    int'(bus8.mismatch),   m_mis[0]);
        chk("mis4",    int'(bus4.mismatch),   m_mis[1]);
`endif
    endtask

    task automatic track();
        if (bus8.meas_valid === 1'b1) begin
            nv8++;
            if (lt8 >= 0) iv8 = t - lt8;
            lt8 = t;
            lh8 = int'(bus8.high_cnt);
            ll8 = int'(bus8.low_cnt);
            lp8 = int'(bus8.period);
            lo8 = int'(bus8.meas_ovf);
`ifdef CLK_MEAS_CHECK_EN
            q_mis.push_back(bus8.mismatch);
`endif
        end
        if (bus4.meas_valid === 1'b1) begin
            nv4++;
            lh4 = int'(bus4.high_cnt);
            ll4 = int'(bus4.low_cnt);
            lp4 = int'(bus4.period);
            lo4 = int'(bus4.meas_ovf);
        end
    endtask

    task automatic drive(input logic s, input logic e);
        bus8.sig_in  = s;
        bus4.sig_in  = s;
        bus8.meas_en = e;
        bus4.meas_en = e;
`ifdef CLK_MEAS_CHECK_EN
        bus8.exp_period = exp_p;
        bus4.exp_period = exp_p[4:0];
`endif
    endtask

    // Called at a negedge: drive, predict, wait for the next negedge, compare.
    task automatic step(input logic s, input logic e);
        drive(s, e);
        model_step(s, e);
        @(negedge clk);
        cmp_all();
        track();
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < hi; j++) step(1'b1, 1'b1);
            for (int j = 0; j < lo; j++) step(1'b0, 1'b1);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_valid8",  int'(bus8.meas_valid), 0);
        chk("rst_high8",   int'(bus8.high_cnt),   0);
        chk("rst_period8", int'(bus8.period),     0);
        chk("rst_valid4",  int'(bus4.meas_valid), 0);
        chk("rst_low4",    int'(bus4.low_cnt),    0);
        chk("rst_ovf4",    int'(bus4.meas_ovf),   0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cmp_all();
    endtask

    function automatic logic en_r();
        return ($urandom_range(0, 99) >= 3);
    endfunction

    initial begin
        int hi, lo;
        t = 0;
        exp_p = 9'd6;
        rst = 1'b1;
        drive(1'b0, 1'b0);
        model_reset();
        nv8 = 0; nv4 = 0; iv8 = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_all();
        chk("init_valid8", int'(bus8.meas_valid), 0);
        chk("init_high8",  int'(bus8.high_cnt),   0);
        chk("init_ovf4",   int'(bus4.meas_ovf),   0);

        // 3 high / 3 low: five rises give four results, six cycles apart
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        nv8 = 0;
        wave(3, 3, 5);
        chk("sq_count", nv8, 4);
        chk("sq_high",  lh8, 3);
        chk("sq_low",   ll8, 3);
        chk("sq_per",   lp8, 6);
        chk("sq_ovf",   lo8, 0);
        chk("sq_gap",   iv8, 6);

        // 2 high / 5 low
        wave(2, 5, 4);
        chk("asym_high", lh8, 2);
        chk("asym_low",  ll8, 5);
        chk("asym_per",  lp8, 7);
        chk("asym_gap",  iv8, 7);

        // long high phase saturates the narrow instance only
        wave(20, 3, 2);
        chk("sat_high4", lh4, 15);
        chk("sat_low4",  ll4, 3);
        chk("sat_per4",  lp4, 18);
        chk("sat_ovf4",  lo4, 1);
        chk("sat_high8", lh8, 20);
        chk("sat_ovf8",  lo8, 0);
        wave(3, 3, 2);
        chk("post_ovf4",  lo4, 0);
        chk("post_high4", lh4, 3);

        // meas_en dropped in MEAS_LOW, held low while sig_in toggles
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        nv8 = 0;
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        chk("idle_nvalid", nv8, 0);
        chk("idle_high",   int'(bus8.high_cnt), 3);
        chk("idle_per",    int'(bus8.period),   6);
        nv8 = 0;
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        wave(3, 3, 3);
        chk("reen_count", nv8, 2);

        // publishing rise in the same cycle meas_en drops
        nv8 = 0;
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        chk("simul_count", nv8, 1);
        chk("simul_high",  lh8, 3);
        chk("simul_low",   ll8, 3);

        // reset in MEAS_HIGH, then a clean restart
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        wave(3, 3, 2);
        step(1'b1, 1'b1);
        mid_reset();
        nv8 = 0;
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        wave(3, 3, 3);
        chk("rst_restart_count", nv8, 2);
        chk("rst_restart_high",  lh8, 3);

`ifdef CLK_MEAS_CHECK_EN
        // exp_period=6 against alternating 6- and 7-cycle periods
        mid_reset();
        q_mis.delete();
        exp_p = 9'd6;
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        wave(3, 3, 1); wave(3, 4, 1); wave(3, 3, 1); wave(3, 4, 1);
        step(1'b1, 1'b1);
        chk("mis_count", q_mis.size(), 4);
        for (int i = 0; i < q_mis.size() && i < 4; i++)
            chk("mis_seq", int'(q_mis[i]), i % 2);
`endif

        // randomized segments with occasional meas_en drops and resets
        for (int seg = 0; seg < 150; seg++) begin
            hi = $urandom_range(1, 20);
            lo = $urandom_range(1, 20);
            exp_p = ($urandom_range(0, 1) == 1) ? 9'(hi + lo) : 9'($urandom_range(2, 31));
            if (hi + lo > 31) exp_p = 9'($urandom_range(2, 31));
            for (int j = 0; j < hi; j++) step(1'b1, en_r());
            if ($urandom_range(0, 19) == 0) mid_reset();
            for (int j = 0; j < lo; j++) step(1'b0, en_r());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
